// File: rtl/dsa_pkg.sv
// dsa_pkg -- shared types and constants for the DSA job controller.
//   job_state_t : controller FSM states (CLEAR, IDLE, LAUNCH, RUN)
//   DSA_CLR_VAL : default byte written while clearing output memory
//   sel_w()     : width of the core-select field, max(1, clog2(ncores))
package dsa_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_LAUNCH = 2'd2,
    ST_RUN    = 2'd3
  } job_state_t;

  localparam logic [7:0] DSA_CLR_VAL = 8'h00;

  function automatic int sel_w(input int ncores);
    return (ncores > 1) ? $clog2(ncores) : 1;
  endfunction

endpackage

// File: rtl/dsa_job_ctrl_if.sv
// dsa_job_ctrl_if -- job/core/memory bundle between the controller and its
// environment (bilinear cores and output memory).
//   mode_sel   : core index for the next job
//   core_done  : per-core done pulses
//   core_waddr / core_wdata / core_we : packed per-core write ports
//   core_start : one-hot start pulse to the selected core
//   mem_waddr / mem_wdata / mem_we    : output-memory write port
// Modports: master = controller side, slave = cores/memory side.
interface dsa_job_ctrl_if #(
  parameter int AW     = 12,
  parameter int NCORES = 2,
  parameter int SW     = dsa_pkg::sel_w(NCORES)
);
  logic [SW-1:0]        mode_sel;
  logic [NCORES-1:0]    core_done;
  logic [NCORES*AW-1:0] core_waddr;
  logic [NCORES*8-1:0]  core_wdata;
  logic [NCORES-1:0]    core_we;
  logic [NCORES-1:0]    core_start;
  logic [AW-1:0]        mem_waddr;
  logic [7:0]           mem_wdata;
  logic                 mem_we;

  modport master (
    input  mode_sel, core_done, core_waddr, core_wdata, core_we,
    output core_start, mem_waddr, mem_wdata, mem_we
  );

  modport slave (
    output mode_sel, core_done, core_waddr, core_wdata, core_we,
    input  core_start, mem_waddr, mem_wdata, mem_we
  );
endinterface

// File: rtl/dsa_sw_debounce.sv
// dsa_sw_debounce -- two-flop synchroniser, counter debounce and rising-edge
// pulse for a raw physical switch.
//   clk_50     : system clock
//   rst_n      : asynchronous active-low reset
//   sw_in      : raw asynchronous switch input
//   level      : debounced switch level
//   rise_pulse : one-cycle pulse when level is accepted going high
// A new level is accepted once the synchronised input has differed from the
// current level for 2^DEB_W-1 consecutive cycles (DEB_W >= 2).
module dsa_sw_debounce #(
  parameter int DEB_W = 20
) (
  input  logic clk_50,
  input  logic rst_n,
  input  logic sw_in,
  output logic level,
  output logic rise_pulse
);

  // Count value present during the last required stable cycle (2^DEB_W-2).
  localparam logic [DEB_W-1:0] CNT_LAST = {{(DEB_W-1){1'b1}}, 1'b0};

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             rise_r;
  logic [DEB_W-1:0] cnt_r;

  // Synchroniser flops for the asynchronous switch.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= sw_in;
      sync2_r <= sync1_r;
    end
  end

  // Stability counter; any bounce back to the current level restarts it.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {DEB_W{1'b0}};
      level_r <= 1'b0;
      rise_r  <= 1'b0;
    end else if (sync2_r == level_r) begin
      cnt_r  <= {DEB_W{1'b0}};
      rise_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r   <= {DEB_W{1'b0}};
      level_r <= sync2_r;
      rise_r  <= sync2_r;
    end else begin
      cnt_r  <= cnt_r + {{(DEB_W-1){1'b0}}, 1'b1};
      rise_r <= 1'b0;
    end
  end

  assign level      = level_r;
  assign rise_pulse = rise_r;

endmodule

// File: rtl/dsa_job_ctrl.sv
// dsa_job_ctrl -- job controller for a bank of bilinear cores sharing one
// output memory. After reset it clears the memory, then launches jobs on
// the core chosen by mode_sel and routes that core's writes to the memory.
//   clk_50, rst_n       : clock, asynchronous active-low reset
//   start_sw            : raw start switch (debounced internally)
//   start_req, clr_req  : one-cycle host start / re-clear requests
//   bus (master)        : mode_sel, core done/start/write ports, memory port
//   busy                : high in CLEAR or RUN
//   done_led            : latched job-complete flag
//   sel_err             : sticky rejected-start flag (mode_sel >= NCORES)
//   cycle_cnt           : RUN-cycle count of the last/current job
// Optional feature macro: DSA_CYCLE_CNT_EN enables the cycle counter;
// without it cycle_cnt is constant 0.
module dsa_job_ctrl
  import dsa_pkg::*;
#(
  parameter int         AW      = 12,
  parameter int         NCORES  = 2,
  parameter int         DEB_W   = 20,
  parameter logic [7:0] CLR_VAL = DSA_CLR_VAL
) (
  input  logic                clk_50,
  input  logic                rst_n,
  input  logic                start_sw,
  input  logic                start_req,
  input  logic                clr_req,
  dsa_job_ctrl_if.master      bus,
  output logic                busy,
  output logic                done_led,
  output logic                sel_err,
  output logic [31:0]         cycle_cnt
);

  localparam int SW = sel_w(NCORES);
  localparam int DW = 8;

  job_state_t        state_r;
  job_state_t        state_s;
  logic [AW-1:0]     clr_cnt_r;
  logic              pending_r;
  logic [SW-1:0]     sel_q_r;
  logic              sel_err_r;
  logic              done_led_r;

  logic              sw_level_s;
  logic              sw_rise_s;
  logic              start_any_s;
  logic              go_s;
  logic              sel_ok_s;
  logic              done_sel_s;

  logic [NCORES-1:0] core_start_s;
  logic [AW-1:0]     mem_waddr_s;
  logic [DW-1:0]     mem_wdata_s;
  logic              mem_we_s;

  dsa_sw_debounce #(.DEB_W(DEB_W)) u_deb (
    .clk_50     (clk_50),
    .rst_n      (rst_n),
    .sw_in      (start_sw),
    .level      (sw_level_s),
    .rise_pulse (sw_rise_s)
  );

  // The edge pulse is qualified with the accepted level it reports.
  assign start_any_s = (sw_rise_s & sw_level_s) | start_req;
  assign go_s        = start_any_s | pending_r;
  assign sel_ok_s    = (32'(bus.mode_sel) < NCORES);
  assign done_sel_s  = bus.core_done[sel_q_r];

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_cnt_r == {AW{1'b1}}) state_s = ST_IDLE;
        else                         state_s = ST_CLEAR;
      end
      ST_IDLE: begin
        if (clr_req)               state_s = ST_CLEAR;
        else if (go_s && sel_ok_s) state_s = ST_LAUNCH;
        else                       state_s = ST_IDLE;
      end
      ST_LAUNCH: state_s = ST_RUN;
      ST_RUN: begin
        if (done_sel_s) state_s = ST_IDLE;
        else            state_s = ST_RUN;
      end
      default: state_s = ST_CLEAR;
    endcase
  end

  // Output decode: clear writes, launch pulse, and RUN-time write mirroring.
  always_comb begin
    core_start_s = {NCORES{1'b0}};
    mem_waddr_s  = {AW{1'b0}};
    mem_wdata_s  = {DW{1'b0}};
    mem_we_s     = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_wdata_s = CLR_VAL;
        mem_waddr_s = clr_cnt_r;
      end
      ST_LAUNCH: core_start_s[sel_q_r] = 1'b1;
      ST_RUN: begin
        mem_waddr_s = bus.core_waddr[int'(sel_q_r)*AW +: AW];
        mem_wdata_s = bus.core_wdata[int'(sel_q_r)*DW +: DW];
        mem_we_s    = bus.core_we[sel_q_r];
      end
      default: begin
        core_start_s = {NCORES{1'b0}};
        mem_we_s     = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) state_r <= ST_CLEAR;
    else        state_r <= state_s;
  end

  // Clear counter, pending start, core selection and status flags.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt_r  <= {AW{1'b0}};
      pending_r  <= 1'b0;
      sel_q_r    <= {SW{1'b0}};
      sel_err_r  <= 1'b0;
      done_led_r <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          clr_cnt_r <= clr_cnt_r + {{(AW-1){1'b0}}, 1'b1};
          pending_r <= pending_r | start_any_s;
        end
        ST_IDLE: begin
          if (clr_req) begin
            clr_cnt_r <= {AW{1'b0}};
          end else if (go_s && sel_ok_s) begin
            sel_q_r    <= bus.mode_sel;
            pending_r  <= 1'b0;
            sel_err_r  <= 1'b0;
            done_led_r <= 1'b0;
          end else if (go_s) begin
            // Invalid core index: drop the start and flag it.
            pending_r <= 1'b0;
            sel_err_r <= 1'b1;
          end
        end
        ST_LAUNCH: pending_r <= pending_r | start_any_s;
        ST_RUN: begin
          pending_r <= pending_r | start_any_s;
          if (done_sel_s) done_led_r <= 1'b1;
        end
        default: pending_r <= 1'b0;
      endcase
    end
  end

`ifdef DSA_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_r;

  // RUN-cycle counter: zeroed on the way into LAUNCH, saturates at all-ones.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_r <= 32'd0;
    end else if (state_s == ST_LAUNCH) begin
      cycle_cnt_r <= 32'd0;
    end else if ((state_r == ST_RUN) && (cycle_cnt_r != 32'hFFFF_FFFF)) begin
      cycle_cnt_r <= cycle_cnt_r + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_r;
`else
  assign cycle_cnt = 32'd0;
`endif

  assign bus.core_start = core_start_s;
  assign bus.mem_waddr  = mem_waddr_s;
  assign bus.mem_wdata  = mem_wdata_s;
  assign bus.mem_we     = mem_we_s;
  assign busy           = (state_r == ST_CLEAR) || (state_r == ST_RUN);
  assign done_led       = done_led_r;
  assign sel_err        = sel_err_r;

endmodule

// File: doc/dsa_job_ctrl.md
DSA_JOB_CTRL -- requirements
Module: dsa_job_ctrl

Interface
REQ-001 SHALL have parameter AW, default 12: output-memory address width; clear depth = 2^AW.
REQ-002 SHALL have parameter NCORES, default 2: number of attached bilinear cores (1..8).
REQ-003 SHALL have parameter DEB_W, default 20: start-switch debounce counter width.
REQ-004 SHALL have parameter CLR_VAL, default 8'h00: byte written during memory clear.
REQ-005 SHALL derive SW = max(1, clog2(NCORES)) as the width of the core-select field.
REQ-006 clk_50  in  1  single system clock, rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 start_sw  in  1  raw physical start switch, asynchronous.
REQ-009 start_req  in  1  synchronous one-cycle host start pulse.
REQ-010 clr_req  in  1  synchronous one-cycle request to re-clear output memory.
REQ-011 mode_sel  in  SW  core index for the next job.
REQ-012 core_done  in  NCORES  per-core done pulse.
REQ-013 core_waddr / core_wdata / core_we  in  NCORES*AW / NCORES*8 / NCORES  packed per-core write ports.
REQ-014 core_start  out  NCORES  one-hot one-cycle start pulse.
REQ-015 mem_waddr / mem_wdata / mem_we  out  AW / 8 / 1  output-memory write port.
REQ-016 busy  out  1  high in CLEAR or RUN.
REQ-017 done_led  out  1  latched job-complete flag.
REQ-018 sel_err  out  1  sticky flag: start rejected because mode_sel >= NCORES.
REQ-019 cycle_cnt  out  32  RUN-cycle count of the last or current job.

Function
REQ-020 SHALL synchronise start_sw through two flops, debounce it (value accepted after 2^DEB_W-1 stable cycles), and emit a one-cycle pulse on its debounced rising edge.
REQ-021 SHALL define start_any = debounced pulse OR start_req.
REQ-022 SHALL implement FSM states CLEAR, IDLE, LAUNCH, RUN.
REQ-023 CLEAR: mem_we=1, mem_wdata=CLR_VAL, mem_waddr=clear counter incrementing each cycle; after address 2^AW-1 is written, go to IDLE; exactly 2^AW write cycles.
REQ-024 IDLE: clr_req -> CLEAR (counter reset to 0); else (start_any or pending) with mode_sel < NCORES -> LAUNCH, latching mode_sel into sel_q and clearing pending; clr_req has priority over start.
REQ-025 start with mode_sel >= NCORES in IDLE SHALL be discarded and set sel_err; sel_err clears on next accepted start.
REQ-026 LAUNCH: core_start[sel_q]=1 for exactly this cycle, cycle_cnt cleared to 0, done_led cleared, then RUN.
REQ-027 RUN: mem_* SHALL mirror core port sel_q combinationally; cycle_cnt increments per cycle, saturating at 2^32-1; core_done[sel_q] -> IDLE and set done_led the following edge.
REQ-028 core_done from non-selected cores SHALL be ignored; mode_sel changes during RUN SHALL not affect sel_q.
REQ-029 start_any during CLEAR, LAUNCH or RUN SHALL set a one-deep pending flag (further starts merge); clr_req outside IDLE SHALL be ignored.
REQ-030 Outside CLEAR and RUN, mem_we SHALL be 0 and core_start all 0.
REQ-031 done_led SHALL hold until the next LAUNCH or reset.

Reset
REQ-032 Reset SHALL enter CLEAR with clear counter 0, pending=0, sel_q=0, sel_err=0, done_led=0, cycle_cnt=0, core_start=0, debounce state 0; mid-job reset abandons the job and restarts clearing.

Configuration
REQ-033 With DSA_CYCLE_CNT_EN defined, cycle_cnt SHALL behave as REQ-026/027; without it, cycle_cnt SHALL be tied to 0 and no counter flops synthesised.

Structure
REQ-034 Package dsa_pkg SHALL hold the FSM state enum (job_state_t) and the CLR_VAL default constant.
REQ-035 Debounce/edge logic SHALL be sub-module dsa_sw_debounce (params DEB_W; ports clk_50, rst_n, sw_in, level, rise_pulse).

Verification
REQ-036 AW=4: release reset -> mem_we=1 for exactly 16 cycles, addresses 0..15, data CLR_VAL, then busy=0.
REQ-037 start_req during CLEAR -> pending; core_start[mode_sel] pulses 2 cycles after CLEAR exits, once only.
REQ-038 NCORES=2, mode_sel=1, start, core_done[1] after 100 RUN cycles -> cycle_cnt=100, done_led=1; core_done[0] earlier ignored.
REQ-039 NCORES=3, mode_sel=3, start -> no core_start, sel_err=1; mode_sel=0 then start -> sel_err=0, launch.
REQ-040 DEB_W=4: 3-cycle glitch on start_sw -> no launch; stable high 20 cycles -> one launch.
REQ-041 rst_n low in RUN -> all outputs reset immediately; CLEAR restarts at address 0.
